// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles the request, response and datapath buses of the ALU operation
//   sequencer. clk/reset are not part of the bundle.
//   master : requester plus datapath side (drives req_*, resp_ready, dp_result)
//   slave  : the sequencer (drives req_ready, dp_*, resp_*, mul_busy)
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  dp_signal;
    logic [31:0] dp_dataA;
    logic [31:0] dp_dataB;
    logic [31:0] dp_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mul_busy;

    modport master (
        output req_valid, req_funct, req_a, req_b, resp_ready, dp_result,
        input  req_ready, dp_signal, dp_dataA, dp_dataB,
               resp_valid, resp_data, resp_err, mul_busy
    );

    modport slave (
        input  req_valid, req_funct, req_a, req_b, resp_ready, dp_result,
        output req_ready, dp_signal, dp_dataA, dp_dataB,
               resp_valid, resp_data, resp_err, mul_busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front-end controller for the 32-bit ALU/shifter/multiplier/HiLo datapath.
//   Takes one operation at a time from the request channel, drives the
//   datapath Signal/operand buses for the required number of cycles and
//   returns the result on the response channel. MFHI/MFLO (and MULTU) wait
//   until an in-flight multiply has finished.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - alu_op_sequencer_if.slave: req_* (valid/ready request),
//           dp_* (datapath drive/result), resp_* (valid/ready response),
//           mul_busy (multiply in flight)
// Configuration:
//   ALU_SEQ_OVERLAP_MUL_EN - when defined, ALU-group ops and illegal codes
//   may run while a multiply is in flight; otherwise all ops serialise.
module alu_op_sequencer #(
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned MUL_CYCLES = 32,
    parameter logic [5:0]  NOP_CODE   = 6'b111111
) (
    input logic               clk,
    input logic               reset,
    alu_op_sequencer_if.slave bus
);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {IDLE, HAZ, EXEC, RESP} state_t;

    function automatic logic is_alu_op(input logic [5:0] f);
        case (f)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul_op(input logic [5:0] f);
        return f == F_MULTU;
    endfunction

    function automatic logic is_mf_op(input logic [5:0] f);
        return (f == F_MFHI) || (f == F_MFLO);
    endfunction

    function automatic logic is_legal(input logic [5:0] f);
        return is_alu_op(f) || is_mul_op(f) || is_mf_op(f);
    endfunction

    // Ops that must wait for the multiplier to drain before issuing.
    function automatic logic must_wait(input logic [5:0] f);
`ifdef ALU_SEQ_OVERLAP_MUL_EN
        return is_mul_op(f) || is_mf_op(f);
`else
        return (f == f);
`endif
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  funct_q, funct_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  exec_cnt_q, exec_cnt_d;
    logic [5:0]  mul_cnt_q, mul_cnt_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic accept;
    logic exec_last;

    assign accept    = bus.req_valid && (state_q == IDLE);
    // MULTU only needs the one-cycle start pulse; everything else holds
    // the datapath for ALU_LAT cycles.
    assign exec_last = is_mul_op(funct_q) || (exec_cnt_q == 3'(ALU_LAT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((mul_cnt_q != '0) && must_wait(bus.req_funct)) begin
                        state_d = HAZ;
                    end else if (!is_legal(bus.req_funct)) begin
                        state_d = RESP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            HAZ: begin
                // An illegal code that waited here still never issues.
                if (mul_cnt_q == '0) begin
                    state_d = is_legal(funct_q) ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !reset;
        bus.dp_signal  = (state_q == EXEC) ? funct_q : NOP_CODE;
        bus.resp_valid = (state_q == RESP);
        bus.mul_busy   = (mul_cnt_q != '0);
        bus.dp_dataA   = a_q;
        bus.dp_dataB   = b_q;
        bus.resp_data  = resp_data_q;
        bus.resp_err   = resp_err_q;
    end

    // Operand, result and counter next-values
    always_comb begin
        funct_d     = funct_q;
        a_d         = a_q;
        b_d         = b_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        exec_cnt_d  = '0;
        mul_cnt_d   = mul_cnt_q;

        if (accept) begin
            funct_d     = bus.req_funct;
            a_d         = bus.req_a;
            b_d         = bus.req_b;
            resp_data_d = '0;
            resp_err_d  = !is_legal(bus.req_funct);
        end

        if (state_q == EXEC) begin
            exec_cnt_d = exec_cnt_q + 3'd1;
            if (exec_last) begin
                resp_data_d = is_mul_op(funct_q) ? '0 : bus.dp_result;
            end
        end

        // Load wins over the background decrement.
        if ((state_q == EXEC) && is_mul_op(funct_q)) begin
            mul_cnt_d = 6'(MUL_CYCLES);
        end else if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            exec_cnt_q  <= '0;
            mul_cnt_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            funct_q     <= funct_d;
            a_q         <= a_d;
            b_q         <= b_d;
            exec_cnt_q  <= exec_cnt_d;
            mul_cnt_q   <= mul_cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int unsigned MUL_CYCLES = 32;
    localparam logic [5:0]  NOP        = 6'b111111;
    localparam logic [5:0]  F_AND   = 6'b100100;
    localparam logic [5:0]  F_OR    = 6'b100101;
    localparam logic [5:0]  F_ADD   = 6'b100000;
    localparam logic [5:0]  F_SUB   = 6'b100010;
    localparam logic [5:0]  F_SLT   = 6'b101010;
    localparam logic [5:0]  F_SLL   = 6'b000000;
    localparam logic [5:0]  F_MULTU = 6'b011001;
    localparam logic [5:0]  F_MFHI  = 6'b010000;
    localparam logic [5:0]  F_MFLO  = 6'b010010;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .ALU_LAT(1),
        .MUL_CYCLES(MUL_CYCLES),
        .NOP_CODE(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Datapath model: combinational ALU, Hi/Lo written MUL_CYCLES edges
    // after the MULTU start pulse.
    logic [31:0] hi = '0;
    logic [31:0] lo = '0;
    logic [63:0] pend = '0;
    int          tcnt = 0;

    always_comb begin
        case (bus.dp_signal)
            F_AND:   bus.dp_result = bus.dp_dataA & bus.dp_dataB;
            F_OR:    bus.dp_result = bus.dp_dataA | bus.dp_dataB;
            F_ADD:   bus.dp_result = bus.dp_dataA + bus.dp_dataB;
            F_SUB:   bus.dp_result = bus.dp_dataA - bus.dp_dataB;
            F_SLT:   bus.dp_result = ($signed(bus.dp_dataA) < $signed(bus.dp_dataB)) ? 32'd1 : 32'd0;
            F_SLL:   bus.dp_result = bus.dp_dataA << bus.dp_dataB[4:0];
            F_MFHI:  bus.dp_result = hi;
            F_MFLO:  bus.dp_result = lo;
            default: bus.dp_result = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.dp_signal == F_MULTU) begin
            pend <= {32'd0, bus.dp_dataA} * {32'd0, bus.dp_dataB};
            tcnt <= MUL_CYCLES;
        end else if (tcnt != 0) begin
            tcnt <= tcnt - 1;
            if (tcnt == 1) begin
                hi <= pend[63:32];
                lo <= pend[31:0];
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_funct = f;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // From the cycle-1 negedge, count cycles until resp_valid (bounded).
    task automatic wait_resp(input int budget, output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_funct = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'd0 ||
            bus.resp_err !== 1'b0 || bus.dp_signal !== NOP || bus.dp_dataA !== 32'd0 ||
            bus.dp_dataB !== 32'd0 || bus.mul_busy !== 1'b0) begin
            $display("FAIL reset_state: rdy=%b rv=%b rd=%h re=%b sig=%b A=%h B=%h busy=%b, required 0 0 0 0 111111 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err,
                     bus.dp_signal, bus.dp_dataA, bus.dp_dataB, bus.mul_busy);
            miscompares++;
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: got %b, required 1", bus.req_ready);
            miscompares++;
        end
    endtask

    task automatic test_add;
        send(F_ADD, 32'd5, 32'd7);
        vectors++;
        if (bus.dp_signal !== F_ADD || bus.dp_dataA !== 32'd5 || bus.dp_dataB !== 32'd7 || bus.resp_valid !== 1'b0) begin
            $display("FAIL add_cycle1: sig=%b A=%0d B=%0d rv=%b, required 100000 5 7 0",
                     bus.dp_signal, bus.dp_dataA, bus.dp_dataB, bus.resp_valid);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd12 || bus.resp_err !== 1'b0 || bus.dp_signal !== NOP) begin
            $display("FAIL add_cycle2: rv=%b data=%0d err=%b sig=%b, required 1 12 0 111111",
                     bus.resp_valid, bus.resp_data, bus.resp_err, bus.dp_signal);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            $display("FAIL add_cycle3: rdy=%b rv=%b, required 1 0", bus.req_ready, bus.resp_valid);
            miscompares++;
        end
    endtask

    task automatic test_alu_mix;
        logic [5:0]  fs [4] = '{F_OR, F_SLT, F_SLL, F_SLT};
        logic [31:0] as [4] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'd1};
        logic [31:0] bs [4] = '{32'd10, 32'd1, 32'd4, 32'hFFFF_FFFF};
        logic [31:0] ex [4] = '{32'd15, 32'd1, 32'd16, 32'd0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(fs[i], as[i], bs[i]);
            wait_resp(10, lat);
            vectors++;
            if (bus.resp_valid !== 1'b1 || lat != 2 || bus.resp_data !== ex[i]) begin
                $display("FAIL alu_mix[%0d]: rv=%b lat=%0d data=%h, required 1 2 %h",
                         i, bus.resp_valid, lat, bus.resp_data, ex[i]);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul_hilo;
        int lat;
        int haz_viol = 0;
        send(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        vectors++;
        if (bus.dp_signal !== F_MULTU) begin
            $display("FAIL multu_pulse: sig=%b, required 011001", bus.dp_signal);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd0 || bus.resp_err !== 1'b0 || bus.mul_busy !== 1'b1) begin
            $display("FAIL multu_resp: rv=%b data=%h err=%b busy=%b, required 1 0 0 1",
                     bus.resp_valid, bus.resp_data, bus.resp_err, bus.mul_busy);
            miscompares++;
        end
        @(negedge clk);
        send(F_MFLO, 32'd0, 32'd0);
        lat = 1;
        while (!bus.resp_valid && lat < 200) begin
            if (bus.mul_busy && bus.dp_signal !== NOP) haz_viol++;
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (haz_viol != 0) begin
            $display("FAIL mflo_haz: %0d issue cycles while busy, required 0", haz_viol);
            miscompares++;
        end
        vectors++;
        if (bus.resp_valid !== 1'b1 || lat != MUL_CYCLES + 1 || bus.resp_data !== 32'hFFFF_FFFE || bus.mul_busy !== 1'b0) begin
            $display("FAIL mflo_resp: rv=%b lat=%0d data=%h busy=%b, required 1 %0d fffffffe 0",
                     bus.resp_valid, lat, bus.resp_data, bus.mul_busy, MUL_CYCLES + 1);
            miscompares++;
        end
        @(negedge clk);
        send(F_MFHI, 32'd0, 32'd0);
        wait_resp(10, lat);
        vectors++;
        if (bus.resp_valid !== 1'b1 || lat != 2 || bus.resp_data !== 32'h0000_0001) begin
            $display("FAIL mfhi_resp: rv=%b lat=%0d data=%h, required 1 2 00000001",
                     bus.resp_valid, lat, bus.resp_data);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        send(6'b000111, 32'd9, 32'd9);
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_data !== 32'd0 || bus.dp_signal !== NOP) begin
            $display("FAIL illegal_resp: rv=%b err=%b data=%h sig=%b, required 1 1 0 111111",
                     bus.resp_valid, bus.resp_err, bus.resp_data, bus.dp_signal);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (bus.dp_signal !== NOP || bus.req_ready !== 1'b1) begin
            $display("FAIL illegal_after: sig=%b rdy=%b, required 111111 1", bus.dp_signal, bus.req_ready);
            miscompares++;
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        bus.resp_ready = 1'b0;
        send(F_SUB, 32'd3, 32'd5);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hFFFF_FFFE || bus.req_ready !== 1'b0) begin
                $display("FAIL sub_hold[%0d]: rv=%b data=%h rdy=%b, required 1 fffffffe 0",
                         i, bus.resp_valid, bus.resp_data, bus.req_ready);
                miscompares++;
                bad++;
            end
            if (i != 9) @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            $display("FAIL sub_release: rv=%b rdy=%b, required 0 1", bus.resp_valid, bus.req_ready);
            miscompares++;
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        bus.resp_ready = 1'b0;
        send(F_MULTU, 32'd7, 32'd9);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.mul_busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.dp_signal !== NOP || bus.req_ready !== 1'b0) begin
            $display("FAIL reset_abort: busy=%b rv=%b sig=%b rdy=%b, required 0 0 111111 0",
                     bus.mul_busy, bus.resp_valid, bus.dp_signal, bus.req_ready);
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.mul_busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            $display("FAIL post_abort: rv=%b busy=%b rdy=%b, required 0 0 1",
                     bus.resp_valid, bus.mul_busy, bus.req_ready);
            miscompares++;
        end
        send(F_MFHI, 32'd0, 32'd0);
        wait_resp(10, lat);
        vectors++;
        if (bus.resp_valid !== 1'b1 || lat != 2 || bus.resp_err !== 1'b0) begin
            $display("FAIL mfhi_no_haz: rv=%b lat=%0d err=%b, required 1 2 0",
                     bus.resp_valid, lat, bus.resp_err);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_overlap;
        int lat;
        int exp_lat;
        logic exp_busy;
`ifdef ALU_SEQ_OVERLAP_MUL_EN
        exp_lat  = 2;
        exp_busy = 1'b1;
`else
        exp_lat  = MUL_CYCLES + 1;
        exp_busy = 1'b0;
`endif
        send(F_MULTU, 32'd3, 32'd3);
        @(negedge clk);
        @(negedge clk);
        send(F_AND, 32'd12, 32'd10);
        wait_resp(200, lat);
        vectors++;
        if (bus.resp_valid !== 1'b1 || lat != exp_lat || bus.resp_data !== 32'd8 || bus.mul_busy !== exp_busy) begin
            $display("FAIL and_during_mul: rv=%b lat=%0d data=%0d busy=%b, required 1 %0d 8 %b",
                     bus.resp_valid, lat, bus.resp_data, bus.mul_busy, exp_lat, exp_busy);
            miscompares++;
        end
        @(negedge clk);
        repeat (40) @(negedge clk);
        vectors++;
        if (bus.mul_busy !== 1'b0) begin
            $display("FAIL mul_drain: busy=%b, required 0", bus.mul_busy);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_mix();
        test_mul_hilo();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        test_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
